// File: rtl/sw_pe_affine_pos_if.sv
// Stream bus between neighbouring Smith-Waterman processing elements.
// The slave side is the PE. It receives the target stream, left-neighbour
// scores and penalties, and drives registered scores to the right neighbour.
// The master side is whatever feeds the PE (the left PE or a testbench).
// Ports:
//   inputs to the PE  : en_in, data_in, query, M_in, I_in, High_in,
//                       HighPos_in, match, mismatch, gap_open, gap_extend
//   outputs of the PE : data_out, M_out, I_out, High_out, HighPos_out,
//                       en_out, vld
interface sw_pe_affine_pos_if #(
  parameter int SCORE_WIDTH = 12,
  parameter int POS_WIDTH   = 10
);
  logic                   en_in;
  logic [1:0]             data_in;
  logic [1:0]             query;
  logic [SCORE_WIDTH-1:0] M_in;
  logic [SCORE_WIDTH-1:0] I_in;
  logic [SCORE_WIDTH-1:0] High_in;
  logic [POS_WIDTH-1:0]   HighPos_in;
  logic [SCORE_WIDTH-1:0] match;
  logic [SCORE_WIDTH-1:0] mismatch;
  logic [SCORE_WIDTH-1:0] gap_open;
  logic [SCORE_WIDTH-1:0] gap_extend;
  logic [1:0]             data_out;
  logic [SCORE_WIDTH-1:0] M_out;
  logic [SCORE_WIDTH-1:0] I_out;
  logic [SCORE_WIDTH-1:0] High_out;
  logic [POS_WIDTH-1:0]   HighPos_out;
  logic                   en_out;
  logic                   vld;

  modport master (
    output en_in, data_in, query, M_in, I_in, High_in, HighPos_in,
           match, mismatch, gap_open, gap_extend,
    input  data_out, M_out, I_out, High_out, HighPos_out, en_out, vld
  );

  modport slave (
    input  en_in, data_in, query, M_in, I_in, High_in, HighPos_in,
           match, mismatch, gap_open, gap_extend,
    output data_out, M_out, I_out, High_out, HighPos_out, en_out, vld
  );
endinterface

// File: rtl/sw_pe_affine_pos.sv
// Smith-Waterman processing element with affine gap penalties. It tracks the
// best score position. Each PE holds one query base and scores one cell per
// target base. Scores are biased (ZERO means 0) and compared unsigned.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - sw_pe_affine_pos_if.slave (target stream, neighbour scores,
//          penalties in; registered scores, en_out, vld out)
// Build option: define SW_SAT_EN to make every penalty addition saturate
// to [0, 2**SCORE_WIDTH-1]. Otherwise, additions wrap.
module sw_pe_affine_pos #(
  parameter int                     SCORE_WIDTH = 12,
  parameter int                     POS_WIDTH   = 10,
  parameter logic [SCORE_WIDTH-1:0] ZERO        = {1'b1, {(SCORE_WIDTH-1){1'b0}}}
) (
  input logic              clk,
  input logic              rst,
  sw_pe_affine_pos_if.slave bus
);
  localparam int SW = SCORE_WIDTH;
  typedef logic [SW-1:0]        score_t;
  typedef logic [POS_WIDTH-1:0] pos_t;
  typedef enum logic [1:0] {WAIT = 2'b01, CALC = 2'b10} state_t;

  function automatic score_t add_pen(input score_t a, input score_t p);
`ifdef SW_SAT_EN
    // Two extra bits: bit SW+1 flags a negative result and bit SW flags an overflow.
    logic [SW+1:0] s;
    s = {2'b00, a} + {{2{p[SW-1]}}, p};
    if (s[SW+1]) return '0;
    if (s[SW])   return '1;
    return s[SW-1:0];
`else
    return a + p;
`endif
  endfunction

  function automatic score_t umax(input score_t a, input score_t b);
    return (a > b) ? a : b;
  endfunction

  state_t state_q, state_d;
  score_t m_out_q, m_out_d, i_out_q, i_out_d, high_q, high_d;
  score_t m_diag_q, m_diag_d, i_diag_q, i_diag_d;
  pos_t   hpos_q, hpos_d, col_q, col_d;
  logic [1:0] data_out_q, data_out_d;
  logic   en_out_q, en_out_d, vld_q, vld_d;

  // The first cell of a stream sees ZERO on its diagonal, up and left sides.
  logic   first;
  score_t diag_m, diag_i, up_m, up_i, left_m, left_i, lut;
  score_t m_sum, m_new, i_open, i_ext, i_new, cand;
  pos_t   col_nxt;
  score_t hi_sel;
  pos_t   pos_sel;

  assign first   = (state_q == WAIT);
  assign diag_m  = first ? ZERO : m_diag_q;
  assign diag_i  = first ? ZERO : i_diag_q;
  assign up_m    = first ? ZERO : m_out_q;
  assign up_i    = first ? ZERO : i_out_q;
  assign left_m  = first ? ZERO : bus.M_in;
  assign left_i  = first ? ZERO : bus.I_in;
  assign lut     = (bus.data_in == bus.query) ? bus.match : bus.mismatch;
  assign m_sum   = add_pen(umax(diag_m, diag_i), lut);
  // An MSB of 0 means the score is below the bias point, so the local alignment restarts.
  assign m_new   = m_sum[SW-1] ? m_sum : ZERO;
  assign i_open  = add_pen(add_pen(umax(left_m, up_m), bus.gap_open), bus.gap_extend);
  assign i_ext   = add_pen(umax(left_i, up_i), bus.gap_extend);
  assign i_new   = umax(i_open, i_ext);
  assign cand    = umax(m_new, i_new);
  // The column counter saturates so that long targets report the last column instead of wrapping.
  assign col_nxt = first ? '0 : ((col_q == '1) ? col_q : col_q + POS_WIDTH'(1));

  // Strict greater-than keeps earlier winners on ties: own high, then left high, then this cell.
  always_comb begin
    hi_sel  = first ? ZERO : high_q;
    pos_sel = first ? '0 : hpos_q;
    if (bus.High_in > hi_sel) begin
      hi_sel  = bus.High_in;
      pos_sel = bus.HighPos_in;
    end
    if (cand > hi_sel) begin
      hi_sel  = cand;
      pos_sel = col_nxt;
    end
    if (!hi_sel[SW-1]) hi_sel = ZERO;
  end

  always_comb begin
    state_d    = state_q;
    m_out_d    = m_out_q;
    i_out_d    = i_out_q;
    high_d     = high_q;
    hpos_d     = hpos_q;
    m_diag_d   = m_diag_q;
    i_diag_d   = i_diag_q;
    col_d      = col_q;
    data_out_d = data_out_q;
    en_out_d   = 1'b0;
    vld_d      = 1'b0;
    if ((state_q == WAIT || state_q == CALC) && bus.en_in) begin
      state_d    = CALC;
      m_out_d    = m_new;
      i_out_d    = i_new;
      high_d     = hi_sel;
      hpos_d     = pos_sel;
      m_diag_d   = bus.M_in;
      i_diag_d   = bus.I_in;
      col_d      = col_nxt;
      data_out_d = bus.data_in;
      en_out_d   = 1'b1;
    end else if (state_q == CALC) begin
      // The stream has ended: pulse vld once while holding the final result.
      state_d = WAIT;
      vld_d   = 1'b1;
    end else begin
      // Idle, or an illegal state is being recovered to WAIT.
      state_d    = WAIT;
      m_out_d    = ZERO;
      i_out_d    = ZERO;
      high_d     = ZERO;
      hpos_d     = '0;
      m_diag_d   = ZERO;
      i_diag_d   = ZERO;
      col_d      = '0;
      data_out_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT;
      m_out_q    <= ZERO;
      i_out_q    <= ZERO;
      high_q     <= ZERO;
      hpos_q     <= '0;
      m_diag_q   <= ZERO;
      i_diag_q   <= ZERO;
      col_q      <= '0;
      data_out_q <= 2'b00;
      en_out_q   <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_out_q    <= m_out_d;
      i_out_q    <= i_out_d;
      high_q     <= high_d;
      hpos_q     <= hpos_d;
      m_diag_q   <= m_diag_d;
      i_diag_q   <= i_diag_d;
      col_q      <= col_d;
      data_out_q <= data_out_d;
      en_out_q   <= en_out_d;
      vld_q      <= vld_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.M_out       = m_out_q;
  assign bus.I_out       = i_out_q;
  assign bus.High_out    = high_q;
  assign bus.HighPos_out = hpos_q;
  assign bus.en_out      = en_out_q;
  assign bus.vld         = vld_q;
endmodule

// File: tb/tb_sw_pe_affine_pos.sv
// Self-checking bench for sw_pe_affine_pos. A second instance with
// POS_WIDTH=2 shares the same stimulus so that column saturation can be
// observed. Expected values come from a cell-by-cell dynamic-programming
// model over the stimulus arrays.
module tb_sw_pe_affine_pos;
  localparam int SW   = 12;
  localparam int PW   = 10;
  localparam int Z    = 2048;
  localparam int SMAX = 4095;
  localparam int MAXN = 32;
  typedef logic [SW-1:0] sc_t;
  typedef logic [PW-1:0] pos_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sw_pe_affine_pos_if #(.SCORE_WIDTH(SW), .POS_WIDTH(PW)) bus ();
  sw_pe_affine_pos_if #(.SCORE_WIDTH(SW), .POS_WIDTH(2))  bus2 ();

  sw_pe_affine_pos #(.SCORE_WIDTH(SW), .POS_WIDTH(PW)) dut  (.clk(clk), .rst(rst), .bus(bus));
  sw_pe_affine_pos #(.SCORE_WIDTH(SW), .POS_WIDTH(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.en_in      = bus.en_in;
  assign bus2.data_in    = bus.data_in;
  assign bus2.query      = bus.query;
  assign bus2.M_in       = bus.M_in;
  assign bus2.I_in       = bus.I_in;
  assign bus2.High_in    = bus.High_in;
  assign bus2.HighPos_in = bus.HighPos_in[1:0];
  assign bus2.match      = bus.match;
  assign bus2.mismatch   = bus.mismatch;
  assign bus2.gap_open   = bus.gap_open;
  assign bus2.gap_extend = bus.gap_extend;

  int total = 0;
  int bad   = 0;
  int vld_seen;
  int pm, pmm, pgo, pge;
  pos_t obs_hp;
  logic [1:0] obs_hp2;

  logic [1:0] s_d[MAXN];
  sc_t  s_m[MAXN], s_i[MAXN], s_h[MAXN];
  pos_t s_hp[MAXN];
  sc_t  e_m[MAXN], e_i[MAXN], e_h[MAXN];
  pos_t e_hp[MAXN];
  logic [1:0] e_hp2[MAXN];

  function automatic int padd(input int a, input int p);
    int v;
    v = a + p;
`ifdef SW_SAT_EN
    if (v < 0) v = 0;
    if (v > SMAX) v = SMAX;
`else
    v = v & SMAX;
`endif
    return v;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Recurrence over the target column: diagonal = previous left inputs,
  // up = previous own cell, left = current left inputs.
  task automatic model(input int n);
    for (int k = 0; k < n; k++) begin
      int dm, di, um, ui, lm, li, lut, m, i, cand, hb, hp, hp2;
      if (k == 0) begin
        dm = Z; di = Z; um = Z; ui = Z; lm = Z; li = Z; hb = Z; hp = 0; hp2 = 0;
      end else begin
        dm = int'(s_m[k-1]); di = int'(s_i[k-1]);
        um = int'(e_m[k-1]); ui = int'(e_i[k-1]);
        lm = int'(s_m[k]);   li = int'(s_i[k]);
        hb = int'(e_h[k-1]); hp = int'(e_hp[k-1]); hp2 = int'(e_hp2[k-1]);
      end
      lut = (s_d[k] == bus.query) ? pm : pmm;
      m = padd(imax(dm, di), lut);
      if (m < Z) m = Z;
      i = imax(padd(padd(imax(lm, um), pgo), pge), padd(imax(li, ui), pge));
      cand = imax(m, i);
      if (int'(s_h[k]) > hb) begin
        hb = int'(s_h[k]); hp = int'(s_hp[k]); hp2 = int'(s_hp[k]) % 4;
      end
      if (cand > hb) begin
        hb = cand; hp = (k > 1023) ? 1023 : k; hp2 = (k > 3) ? 3 : k;
      end
      if (hb < Z) hb = Z;
      e_m[k] = sc_t'(m); e_i[k] = sc_t'(i); e_h[k] = sc_t'(hb);
      e_hp[k] = pos_t'(hp); e_hp2[k] = 2'(hp2);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pens(input int m, input int mm, input int go, input int ge);
    pm = m; pmm = mm; pgo = go; pge = ge;
    bus.match = sc_t'(m); bus.mismatch = sc_t'(mm);
    bus.gap_open = sc_t'(go); bus.gap_extend = sc_t'(ge);
  endtask

  task automatic drive(input int k);
    bus.en_in = 1'b1; bus.data_in = s_d[k]; bus.M_in = s_m[k]; bus.I_in = s_i[k];
    bus.High_in = s_h[k]; bus.HighPos_in = s_hp[k];
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      s_d[k] = 2'($urandom_range(0, 3));
      s_m[k] = sc_t'($urandom); s_i[k] = sc_t'($urandom);
      s_h[k] = sc_t'($urandom); s_hp[k] = pos_t'($urandom);
    end
  endtask

  task automatic set_flat(input int n, input logic [1:0] d);
    for (int k = 0; k < n; k++) begin
      s_d[k] = d; s_m[k] = sc_t'(Z); s_i[k] = sc_t'(Z); s_h[k] = sc_t'(Z); s_hp[k] = '0;
    end
  endtask

  // Streams n cells and checks each cell and the vld cycle against the model.
  // Unless back_to_back is set, it also checks one idle cycle afterwards.
  task automatic run_stream(input int n, input bit back_to_back, input string tag);
    model(n);
    for (int k = 0; k < n; k++) begin
      drive(k);
      tick();
      if (bus.vld) vld_seen++;
      total++;
      if (bus.M_out !== e_m[k] || bus.I_out !== e_i[k]) begin
        bad++;
        $display("FAIL %s cell%0d M/I got=%0d/%0d exp=%0d/%0d", tag, k, bus.M_out, bus.I_out, e_m[k], e_i[k]);
      end
      total++;
      if (bus.High_out !== e_h[k] || bus.HighPos_out !== e_hp[k]) begin
        bad++;
        $display("FAIL %s cell%0d High/Pos got=%0d/%0d exp=%0d/%0d", tag, k, bus.High_out, bus.HighPos_out, e_h[k], e_hp[k]);
      end
      total++;
      if (bus2.HighPos_out !== e_hp2[k]) begin
        bad++;
        $display("FAIL %s cell%0d Pos2 got=%0d exp=%0d", tag, k, bus2.HighPos_out, e_hp2[k]);
      end
      total++;
      if (bus.en_out !== 1'b1 || bus.vld !== 1'b0 || bus.data_out !== s_d[k]) begin
        bad++;
        $display("FAIL %s cell%0d en/vld/data got=%b/%b/%0d exp=1/0/%0d", tag, k, bus.en_out, bus.vld, bus.data_out, s_d[k]);
      end
    end
    bus.en_in = 1'b0;
    tick();
    if (bus.vld) vld_seen++;
    obs_hp = bus.HighPos_out; obs_hp2 = bus2.HighPos_out;
    total++;
    if (bus.vld !== 1'b1 || bus.en_out !== 1'b0 || bus2.vld !== 1'b1) begin
      bad++;
      $display("FAIL %s end vld/en/vld2 got=%b/%b/%b exp=1/0/1", tag, bus.vld, bus.en_out, bus2.vld);
    end
    total++;
    if (bus.High_out !== e_h[n-1] || bus.HighPos_out !== e_hp[n-1] || bus.M_out !== e_m[n-1] || bus2.HighPos_out !== e_hp2[n-1]) begin
      bad++;
      $display("FAIL %s end High/Pos/M/Pos2 got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", tag, bus.High_out, bus.HighPos_out,
               bus.M_out, bus2.HighPos_out, e_h[n-1], e_hp[n-1], e_m[n-1], e_hp2[n-1]);
    end
    if (!back_to_back) begin
      tick();
      if (bus.vld) vld_seen++;
      total++;
      if (bus.vld !== 1'b0 || bus.en_out !== 1'b0 || bus.M_out !== sc_t'(Z) || bus.I_out !== sc_t'(Z) ||
          bus.High_out !== sc_t'(Z) || bus.HighPos_out !== '0 || bus.data_out !== 2'b00) begin
        bad++;
        $display("FAIL %s idle vld/en/M/I/High/Pos got=%b/%b/%0d/%0d/%0d/%0d exp=0/0/2048/2048/2048/0", tag, bus.vld,
                 bus.en_out, bus.M_out, bus.I_out, bus.High_out, bus.HighPos_out);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (bus.M_out !== sc_t'(Z) || bus.I_out !== sc_t'(Z) || bus.High_out !== sc_t'(Z) || bus.HighPos_out !== '0 ||
        bus.en_out !== 1'b0 || bus.vld !== 1'b0 || bus.data_out !== 2'b00 || bus2.HighPos_out !== 2'b00) begin
      bad++;
      $display("FAIL reset M/I/High/Pos/en/vld got=%0d/%0d/%0d/%0d/%b/%b exp=2048/2048/2048/0/0/0", bus.M_out, bus.I_out,
               bus.High_out, bus.HighPos_out, bus.en_out, bus.vld);
    end
    rst = 1'b0;
  endtask

  task automatic test_example;
    int xm[3];
    xm = '{2050, 2048, 2050};
    bus.query = 2'b00;
    set_pens(2, -1, -3, -1);
    set_flat(3, 2'b00);
    s_d[1] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      drive(k);
      tick();
      total++;
      if (bus.M_out !== sc_t'(xm[k]) || bus.I_out !== sc_t'(2047)) begin
        bad++;
        $display("FAIL example cell%0d M/I got=%0d/%0d exp=%0d/2047", k, bus.M_out, bus.I_out, xm[k]);
      end
    end
    bus.en_in = 1'b0;
    tick();
    total++;
    if (bus.vld !== 1'b1 || bus.High_out !== sc_t'(2050) || bus.HighPos_out !== '0) begin
      bad++;
      $display("FAIL example end vld/High/Pos got=%b/%0d/%0d exp=1/2050/0", bus.vld, bus.High_out, bus.HighPos_out);
    end
    tick();
    total++;
    if (bus.vld !== 1'b0) begin
      bad++;
      $display("FAIL example pulse_width vld got=%b exp=0", bus.vld);
    end
  endtask

  task automatic test_saturation;
    int exp1;
`ifdef SW_SAT_EN
    exp1 = 4095;
`else
    exp1 = 2048;
`endif
    bus.query = 2'b00;
    set_pens(5, -1, -3, -1);
    set_flat(2, 2'b00);
    s_m[0] = sc_t'(4094);
    drive(0);
    tick();
    total++;
    if (bus.M_out !== sc_t'(2053)) begin
      bad++;
      $display("FAIL sat cell0 M got=%0d exp=2053", bus.M_out);
    end
    drive(1);
    tick();
    total++;
    if (bus.M_out !== sc_t'(exp1)) begin
      bad++;
      $display("FAIL sat cell1 M got=%0d exp=%0d", bus.M_out, exp1);
    end
    bus.en_in = 1'b0;
    tick();
    tick();
    // Same pattern again, this time against the model.
    run_stream(2, 1'b0, "sat_model");
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 20);
      bus.query = 2'($urandom_range(0, 3));
      set_pens($urandom_range(0, 7), -int'($urandom_range(0, 4)), -int'($urandom_range(0, 5)), -int'($urandom_range(0, 3)));
      fill_random(n);
      run_stream(n, 1'b0, "random");
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_back_to_back;
    vld_seen = 0;
    bus.query = 2'b10;
    set_pens(3, -2, -4, -1);
    fill_random(7);
    run_stream(7, 1'b1, "b2b_first");
    fill_random(5);
    run_stream(5, 1'b0, "b2b_second");
    total++;
    if (vld_seen != 2) begin
      bad++;
      $display("FAIL b2b vld_count got=%0d exp=2", vld_seen);
    end
  endtask

  task automatic test_reset_mid;
    bus.query = 2'b01;
    set_pens(2, -1, -3, -1);
    fill_random(3);
    drive(0);
    tick();
    drive(1);
    tick();
    drive(2);
    rst = 1'b1;
    tick();
    total++;
    if (bus.M_out !== sc_t'(Z) || bus.I_out !== sc_t'(Z) || bus.High_out !== sc_t'(Z) || bus.HighPos_out !== '0 ||
        bus.en_out !== 1'b0 || bus.vld !== 1'b0 || bus.data_out !== 2'b00 || bus2.en_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid M/I/High/Pos/en/vld got=%0d/%0d/%0d/%0d/%b/%b exp=2048/2048/2048/0/0/0", bus.M_out,
               bus.I_out, bus.High_out, bus.HighPos_out, bus.en_out, bus.vld);
    end
    rst = 1'b0;
    bus.en_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (bus.vld !== 1'b0 || bus2.vld !== 1'b0 || bus.M_out !== sc_t'(Z)) begin
        bad++;
        $display("FAIL rst_mid after%0d vld/vld2/M got=%b/%b/%0d exp=0/0/2048", c, bus.vld, bus2.vld, bus.M_out);
      end
    end
  endtask

  task automatic test_pos_saturate;
    bus.query = 2'b00;
    set_pens(2, -1, -3, -1);
    set_flat(6, 2'b00);
    for (int k = 0; k < 6; k++) s_m[k] = sc_t'(Z + 2 * (k + 1));
    run_stream(6, 1'b0, "pos_sat");
    total++;
    if (obs_hp2 !== 2'd3 || obs_hp !== pos_t'(5)) begin
      bad++;
      $display("FAIL pos_sat HighPos narrow/wide got=%0d/%0d exp=3/5", obs_hp2, obs_hp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en_in = 1'b0; bus.data_in = '0; bus.query = '0; bus.M_in = sc_t'(Z); bus.I_in = sc_t'(Z);
    bus.High_in = sc_t'(Z); bus.HighPos_in = '0;
    set_pens(2, -1, -3, -1);
    vld_seen = 0;
    test_reset();
    test_example();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_pos_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
